// File: rtl/prml_read_ctrl.sv
// prml_read_ctrl
// ---------------------------------------------------------------------------
// Read-channel sequencer for the serial PRML Viterbi decoder path.
// A start command clears the decoder. The block then hunts the decoded bit
// stream for a sync word and frames PAYLOAD_LEN payload bits to downstream
// logic while it counts decoder error flags. It finishes in DONE, or in FAIL
// on a sync timeout or on too many errors, and waits there for the host.
//
// Ports
//   clock       system clock
//   reset       synchronous, active-low reset
//   start       begin a sector read (honoured in IDLE, DONE, FAIL)
//   abort       return to IDLE from any state (beats start and bit_valid)
//   bit_valid   one-cycle strobe per decoded bit
//   bit_in      decoded bit, qualified by bit_valid
//   err_in      decoder error flag, qualified by bit_valid
//   dec_clear   held high while the decoder is being cleared
//   busy        high in CLEAR, HUNT, PAYLOAD
//   sync_found  one-cycle pulse on a sync match
//   data_valid  one-cycle strobe per forwarded payload bit
//   data_out    payload bit, qualified by data_valid
//   bit_count   payload bits forwarded this sector
//   err_count   payload error flags this sector (saturating)
//   done        level, sector completed cleanly
//   fail        level, sync timeout or error limit
//   state_dbg   current FSM state encoding, for debug and checkers
//
// Handshake: there is no back-pressure. An input bit is transferred on any
// clock edge where bit_valid=1 and is consumed or dropped in that cycle.
// Every output is registered. data_valid and sync_found are single-cycle
// strobes that appear one cycle after the bit that caused them.
// ---------------------------------------------------------------------------
module prml_read_ctrl #(
   parameter int                SYNC_W       = 8,
   parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5,
   parameter int                HUNT_MAX     = 256,
   parameter int                PAYLOAD_LEN  = 64,
   parameter int                ERR_MAX      = 4,
   parameter int                CLEAR_CYC    = 4,
   parameter int                CNT_W        = 10,
   parameter int                ERR_W        = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             err_in,
   output logic             dec_clear,
   output logic             busy,
   output logic             sync_found,
   output logic             data_valid,
   output logic             data_out,
   output logic [CNT_W-1:0] bit_count,
   output logic [ERR_W-1:0] err_count,
   output logic             done,
   output logic             fail,
   output logic [2:0]       state_dbg
);

   localparam logic [CNT_W-1:0] HUNT_LIMIT = CNT_W'(HUNT_MAX);
   localparam logic [CNT_W-1:0] SYNC_MIN   = CNT_W'(SYNC_W);
   localparam logic [CNT_W-1:0] PAY_LIMIT  = CNT_W'(PAYLOAD_LEN);
   localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYC - 1);
   localparam logic [ERR_W-1:0] ERR_LIMIT  = ERR_W'(ERR_MAX);
   localparam logic [ERR_W-1:0] ERR_SAT    = '1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_HUNT    = 3'd2,
      S_PAYLOAD = 3'd3,
      S_DONE    = 3'd4,
      S_FAIL    = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [SYNC_W-1:0] sreg_q, sreg_nxt;
   logic [CNT_W-1:0]  hunt_cnt_q, hunt_nxt;
   logic [CNT_W-1:0]  clr_cnt_q;
   logic [CNT_W-1:0]  bit_nxt;
   logic [ERR_W-1:0]  err_nxt;

   logic launch, hunt_step, sync_hit, hunt_timeout;
   logic take_bit, err_limit, pay_full;

   logic dec_clear_d, busy_d, sync_found_d, data_valid_d, data_out_d;
   logic done_d, fail_d;

   // -----------------------------------------------------------------------
   // Qualified events. abort masks everything, so counters hold on abort.
   // -----------------------------------------------------------------------
   assign sreg_nxt  = {sreg_q[SYNC_W-2:0], bit_in};
   assign hunt_nxt  = hunt_cnt_q + CNT_W'(1);
   assign bit_nxt   = bit_count + CNT_W'(1);
   assign err_nxt   = (err_in && (err_count != ERR_SAT)) ? err_count + ERR_W'(1)
                                                         : err_count;

   assign launch    = !abort && start &&
                      (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
   assign hunt_step = !abort && (state_q == S_HUNT) && bit_valid;
   // The match is qualified by the bit count so that the zero-filled shift
   // register cannot alias a pattern before SYNC_W real bits have arrived.
   assign sync_hit     = hunt_step && (sreg_nxt == SYNC_PATTERN) && (hunt_nxt >= SYNC_MIN);
   assign hunt_timeout = hunt_step && (hunt_nxt >= HUNT_LIMIT);
   assign take_bit     = !abort && (state_q == S_PAYLOAD) && bit_valid;
   assign err_limit    = take_bit && (err_nxt >= ERR_LIMIT);
   assign pay_full     = take_bit && (bit_nxt >= PAY_LIMIT);

   // -----------------------------------------------------------------------
   // State register
   // -----------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_FAIL: if (start) state_d = S_CLEAR;
            S_CLEAR:   if (clr_cnt_q == CLEAR_LAST) state_d = S_HUNT;
            // A match on the final allowed bit takes priority over timeout.
            S_HUNT: begin
               if (sync_hit)          state_d = S_PAYLOAD;
               else if (hunt_timeout) state_d = S_FAIL;
            end
            // Reaching the error limit on the last bit still counts as a failure.
            S_PAYLOAD: begin
               if (err_limit)     state_d = S_FAIL;
               else if (pay_full) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Output logic. Levels follow the next state, so they are registered
   // and change on the same edge as the state.
   // -----------------------------------------------------------------------
   always_comb begin
      dec_clear_d  = (state_d == S_CLEAR);
      busy_d       = (state_d == S_CLEAR) || (state_d == S_HUNT) || (state_d == S_PAYLOAD);
      done_d       = (state_d == S_DONE);
      fail_d       = (state_d == S_FAIL);
      sync_found_d = sync_hit;
      data_valid_d = take_bit;
      data_out_d   = take_bit ? bit_in : data_out;
   end

   // -----------------------------------------------------------------------
   // Registered outputs and datapath counters
   // -----------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         dec_clear  <= 1'b0;
         busy       <= 1'b0;
         sync_found <= 1'b0;
         data_valid <= 1'b0;
         data_out   <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         bit_count  <= '0;
         err_count  <= '0;
         sreg_q     <= '0;
         hunt_cnt_q <= '0;
         clr_cnt_q  <= '0;
      end else begin
         dec_clear  <= dec_clear_d;
         busy       <= busy_d;
         sync_found <= sync_found_d;
         data_valid <= data_valid_d;
         data_out   <= data_out_d;
         done       <= done_d;
         fail       <= fail_d;
         if (launch) begin
            bit_count  <= '0;
            err_count  <= '0;
            sreg_q     <= '0;
            hunt_cnt_q <= '0;
            clr_cnt_q  <= '0;
         end else begin
            if (!abort && state_q == S_CLEAR) clr_cnt_q <= clr_cnt_q + CNT_W'(1);
            if (hunt_step) begin
               sreg_q     <= sreg_nxt;
               hunt_cnt_q <= hunt_nxt;
            end
            if (take_bit) begin
               bit_count <= bit_nxt;
               err_count <= err_nxt;
            end
         end
      end
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_prml_read_ctrl.sv
// Testbench for prml_read_ctrl.
// A behavioural reference model follows the sector protocol. It tracks the
// phase, keeps a queue of the hunted bits and counts payload bits and errors.
// A compare process checks every DUT output against this model on each
// falling edge. Directed sequences pin the model with literal expectations,
// and randomized traffic follows them.
module tb_prml_read_ctrl;

   localparam int         P_LEN = 8;
   localparam int         H_MAX = 256;
   localparam int         E_MAX = 4;
   localparam int         C_CYC = 4;
   localparam int         CNT_W = 10;
   localparam int         ERR_W = 4;
   localparam logic [7:0] SYNC  = 8'hA5;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             bit_valid = 1'b0;
   logic             bit_in = 1'b0;
   logic             err_in = 1'b0;
   logic             dec_clear, busy, sync_found, data_valid, data_out, done, fail;
   logic [CNT_W-1:0] bit_count;
   logic [ERR_W-1:0] err_count;
   logic [2:0]       state_dbg;

   int errors = 0;
   int checks = 0;
   bit checking = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   prml_read_ctrl #(
      .PAYLOAD_LEN (P_LEN)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .err_in     (err_in),
      .dec_clear  (dec_clear),
      .busy       (busy),
      .sync_found (sync_found),
      .data_valid (data_valid),
      .data_out   (data_out),
      .bit_count  (bit_count),
      .err_count  (err_count),
      .done       (done),
      .fail       (fail),
      .state_dbg  (state_dbg)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_CLEAR, M_HUNT, M_PAYLOAD, M_DONE, M_FAIL} mode_t;
   mode_t mode = M_IDLE;
   int    clear_left = 0;
   bit    hunt_q[$];
   int    m_bits = 0;
   int    m_errs = 0;
   bit    e_sync = 1'b0;
   bit    e_dv = 1'b0;
   bit    e_dout = 1'b0;

   function automatic logic [7:0] last_word();
      logic [7:0] w;
      int n;
      w = '0;
      n = hunt_q.size();
      for (int i = n - 8; i < n; i++) w = {w[6:0], hunt_q[i]};
      return w;
   endfunction

   always @(posedge clock) begin
      if (!reset) begin
         mode = M_IDLE;
         hunt_q.delete();
         m_bits = 0;
         m_errs = 0;
         e_sync = 1'b0;
         e_dv = 1'b0;
         e_dout = 1'b0;
      end else begin
         e_sync = 1'b0;
         e_dv = 1'b0;
         if (abort) begin
            mode = M_IDLE;
         end else begin
            case (mode)
               M_IDLE, M_DONE, M_FAIL: if (start) begin
                  mode = M_CLEAR;
                  clear_left = C_CYC;
                  m_bits = 0;
                  m_errs = 0;
                  hunt_q.delete();
               end
               M_CLEAR: begin
                  clear_left--;
                  if (clear_left == 0) mode = M_HUNT;
               end
               M_HUNT: if (bit_valid) begin
                  hunt_q.push_back(bit_in);
                  if (hunt_q.size() >= 8 && last_word() == SYNC) begin
                     e_sync = 1'b1;
                     mode = M_PAYLOAD;
                  end else if (hunt_q.size() >= H_MAX) begin
                     mode = M_FAIL;
                  end
               end
               M_PAYLOAD: if (bit_valid) begin
                  e_dv = 1'b1;
                  e_dout = bit_in;
                  m_bits++;
                  if (err_in && m_errs < 15) m_errs++;
                  if (m_errs >= E_MAX)      mode = M_FAIL;
                  else if (m_bits == P_LEN) mode = M_DONE;
               end
               default: mode = M_IDLE;
            endcase
         end
      end
   end

   // ---------------- scoreboard compare, every cycle ----------------
   always @(negedge clock) begin
      if (checking) begin
         chk("dec_clear",  32'(dec_clear),  32'(mode == M_CLEAR));
         chk("busy",       32'(busy),       32'(mode == M_CLEAR || mode == M_HUNT || mode == M_PAYLOAD));
         chk("sync_found", 32'(sync_found), 32'(e_sync));
         chk("data_valid", 32'(data_valid), 32'(e_dv));
         if (e_dv) chk("data_out", 32'(data_out), 32'(e_dout));
         chk("bit_count",  32'(bit_count),  32'(m_bits));
         chk("err_count",  32'(err_count),  32'(m_errs));
         chk("done",       32'(done),       32'(mode == M_DONE));
         chk("fail",       32'(fail),       32'(mode == M_FAIL));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic e);
      bit_valid = 1'b1;
      bit_in = b;
      err_in = e;
      tick();
      bit_valid = 1'b0;
      err_in = 1'b0;
   endtask

   task automatic send_word8(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
   endtask

   task automatic launch();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (C_CYC) tick();
   endtask

   task automatic count_clear(input string name);
      int n;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (dec_clear) n++;
         tick();
      end
      chk(name, 32'(n), 32'd4);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [9:0] seq10;
      logic [7:0] word;
      logic [7:0] got;
      logic [7:0] sync_v;
      logic [4:0] part5;
      int         nv;
      int         pat_left;

      sync_v = SYNC;
      tick();
      checking = 1'b1;
      tick();
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done_fail", 32'({done, fail}), 32'd0);
      reset = 1'b1;
      tick();

      // Sync hunt with a leading prefix: match on the 10th strobe.
      start = 1'b1;
      tick();
      start = 1'b0;
      count_clear("dec_clear_cycles");
      seq10 = 10'b0010100101;
      for (int i = 9; i >= 0; i--) begin
         send_bit(seq10[i], 1'b0);
         if (i > 0) chk("busy_in_hunt", 32'(busy), 32'd1);
      end
      chk("sync_pulse", 32'(sync_found), 32'd1);
      tick();
      chk("sync_one_cycle", 32'(sync_found), 32'd0);

      // Clean payload.
      word = 8'b11010010;
      got = '0;
      nv = 0;
      for (int i = 7; i >= 0; i--) begin
         send_bit(word[i], 1'b0);
         if (data_valid) begin
            nv++;
            got = {got[6:0], data_out};
         end
      end
      chk("payload_bits", 32'(got), 32'hD2);
      chk("payload_strobes", 32'(nv), 32'd8);
      chk("payload_count", 32'(bit_count), 32'd8);
      chk("payload_done", 32'(done), 32'd1);
      chk("payload_busy", 32'(busy), 32'd0);
      chk("payload_errs", 32'(err_count), 32'd0);

      // Error limit reached on bit 7; bit 8 is dropped.
      launch();
      send_word8(SYNC);
      chk("sync_err_test", 32'(sync_found), 32'd1);
      for (int k = 1; k <= 7; k++)
         send_bit(1'($urandom_range(0, 1)), 1'(k == 2 || k == 4 || k == 5 || k == 7));
      chk("fail_after_bit7", 32'(fail), 32'd1);
      send_bit(1'b1, 1'b0);
      chk("drop_after_fail", 32'(data_valid), 32'd0);
      chk("fail_count", 32'(bit_count), 32'd7);
      chk("fail_errs", 32'(err_count), 32'd4);

      // Fourth error on the final bit: fail beats done.
      launch();
      send_word8(SYNC);
      for (int k = 1; k <= 8; k++)
         send_bit(1'($urandom_range(0, 1)), 1'(k == 2 || k == 4 || k == 5 || k == 8));
      chk("err_on_final_fail", 32'(fail), 32'd1);
      chk("err_on_final_done", 32'(done), 32'd0);
      chk("err_on_final_count", 32'(bit_count), 32'd8);

      // Hunt timeout after exactly 256 bits.
      launch();
      repeat (H_MAX - 1) send_bit(1'b0, 1'b0);
      chk("no_timeout_255", 32'(fail), 32'd0);
      send_bit(1'b0, 1'b0);
      chk("timeout_256", 32'(fail), 32'd1);
      chk("timeout_busy", 32'(busy), 32'd0);

      // Pattern completing on bit 256 wins over timeout.
      launch();
      repeat (H_MAX - 8) send_bit(1'b0, 1'b0);
      send_word8(SYNC);
      chk("sync_on_256", 32'(sync_found), 32'd1);
      chk("sync_on_256_nofail", 32'(fail), 32'd0);

      // Abort with a simultaneous bit mid-payload.
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b0);
      bit_valid = 1'b1;
      bit_in = 1'b1;
      abort = 1'b1;
      tick();
      bit_valid = 1'b0;
      abort = 1'b0;
      chk("abort_drops_bit", 32'(data_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done_fail", 32'({done, fail}), 32'd0);
      chk("abort_holds_count", 32'(bit_count), 32'd3);
      chk("abort_holds_errs", 32'(err_count), 32'd1);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("abort_beats_start", 32'(busy), 32'd0);
      tick();
      chk("abort_no_clear", 32'(dec_clear), 32'd0);

      // Reset during hunt discards the partial sync.
      launch();
      part5 = 5'b10100;
      for (int i = 4; i >= 0; i--) send_bit(part5[i], 1'b0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("midreset_busy", 32'(busy), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      count_clear("midreset_clear_cycles");
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      chk("partial_sync_discarded", 32'(sync_found), 32'd0);
      send_word8(SYNC);
      chk("resync", 32'(sync_found), 32'd1);

      // Randomized traffic.
      pat_left = 0;
      for (int c = 0; c < 4000; c++) begin
         start = 1'($urandom_range(0, 29) == 0);
         abort = 1'($urandom_range(0, 149) == 0);
         reset = 1'($urandom_range(0, 999) != 0);
         bit_valid = 1'($urandom_range(0, 3) != 0);
         err_in = 1'($urandom_range(0, 11) == 0);
         if (pat_left == 0 && $urandom_range(0, 24) == 0) pat_left = 8;
         if (pat_left > 0) begin
            bit_in = sync_v[pat_left-1];
            if (bit_valid) pat_left--;
         end else begin
            bit_in = 1'($urandom_range(0, 1));
         end
         tick();
      end
      start = 1'b0;
      abort = 1'b0;
      reset = 1'b1;
      bit_valid = 1'b0;
      err_in = 1'b0;
      repeat (3) tick();

      // ---------------- final report ----------------
      checking = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prml_read_ctrl.md
Name: prml_read_ctrl

Overview:
Read-channel sequencer for the serial PRML Viterbi decoder path. On a start command it clears the decoder and hunts the decoded bit stream for a sync word. It then frames PAYLOAD_LEN payload bits to downstream logic while counting decoder error flags. It reports done, or fail on sync timeout or excessive errors, and returns control to the host.

Parameters:
SYNC_W, 8, sync word width in bits
SYNC_PATTERN, 8'hA5, sync word; first received bit is the MSB
HUNT_MAX, 256, max decoded bits examined in HUNT before timeout
PAYLOAD_LEN, 64, payload bits per sector
ERR_MAX, 4, payload error flags that force FAIL
CLEAR_CYC, 4, cycles dec_clear is held high
CNT_W, 10, width of bit_count and internal counters; must hold max(HUNT_MAX, PAYLOAD_LEN)
ERR_W, 4, width of err_count

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  begin sector read; sampled in IDLE, DONE, FAIL
abort  in  1  return to IDLE from any state
bit_valid  in  1  one-cycle strobe per decoded bit from decoder
bit_in  in  1  decoded bit, qualified by bit_valid
err_in  in  1  decoder error flag, qualified by bit_valid
dec_clear  out  1  forces decoder state/sample registers to zero
busy  out  1  high in CLEAR, HUNT, PAYLOAD
sync_found  out  1  one-cycle pulse on sync match
data_valid  out  1  one-cycle strobe per forwarded payload bit
data_out  out  1  payload bit, qualified by data_valid
bit_count  out  CNT_W  payload bits forwarded this sector
err_count  out  ERR_W  payload error flags this sector, saturating
done  out  1  level; sector completed cleanly
fail  out  1  level; timeout or error limit

Behaviour:
- All outputs registered. reset low at a clock edge: state=IDLE; every output, counter and the sync shift register = 0.
- States: IDLE, CLEAR, HUNT, PAYLOAD, DONE, FAIL.
- IDLE/DONE/FAIL + start=1 -> CLEAR. Clear done, fail, bit_count, err_count, sync shift register and hunt counter. start is ignored while busy.
- CLEAR: dec_clear=1 for exactly CLEAR_CYC cycles, then HUNT. bit_valid is ignored.
- HUNT: on bit_valid, sreg <= {sreg[SYNC_W-2:0], bit_in} and hunt_cnt++.
  - If the new sreg == SYNC_PATTERN: sync_found=1 next cycle, go to PAYLOAD.
  - Else if hunt_cnt reaches HUNT_MAX: go to FAIL.
  - A match on the HUNT_MAX-th bit wins over timeout.
  - err_in is ignored in HUNT.
  - Matching starts only after SYNC_W bits have been shifted in, so zero-fill cannot alias the pattern.
- PAYLOAD: on bit_valid, next cycle data_out=bit_in, data_valid=1, bit_count+1 (latency 1).
  - err_in=1 increments err_count, saturating at 2^ERR_W-1.
  - If err_count reaches ERR_MAX: FAIL. The triggering bit is still forwarded.
  - Else if bit_count reaches PAYLOAD_LEN: DONE.
  - If both occur on the final bit, FAIL wins.
  - Bits arriving after the transition are dropped.
- DONE: done=1. FAIL: fail=1. Both hold until start or abort. bit_count and err_count hold their final values.
- abort=1 (any state): next state IDLE. dec_clear, data_valid, sync_found, done, fail = 0. Counters hold for debug.
  - abort beats start and bit_valid in the same cycle.
- reset low mid-sector: immediate return to the reset state at that edge. No partial strobe is emitted.
- bit_valid is never assumed periodic. Back-to-back strobes every cycle must be handled.

Test Plan:
- Reset then start; after 4 dec_clear cycles feed bits 0,0,1,0,1,0,0,1,0,1 -> sync_found pulse one cycle after the 10th strobe; busy=1 throughout.
- After sync (PAYLOAD_LEN=8), feed 8 bits 1,1,0,1,0,0,1,0 with err_in=0 -> 8 data_valid strobes echoing the bits, bit_count=8, done=1, busy=0, err_count=0.
- Payload with err_in=1 on bits 2,4,5,7 (ERR_MAX=4) -> fail=1 one cycle after bit 7, 7 bits forwarded, err_count=4; 4th error on the final bit still gives fail, not done.
- Feed 256 zero bits in HUNT -> fail=1 after the 256th strobe; repeat with the pattern completing on bit 256 -> sync_found, no fail.
- abort asserted mid-PAYLOAD together with bit_valid -> IDLE next cycle, no data_valid for that bit, done=fail=0; start asserted with abort in IDLE -> stays IDLE.
- reset low for one cycle during HUNT, then start -> full CLEAR sequence again, counters 0, prior partial sync ignored.
